// File: rtl/seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Brief    : Multiplexed seven-segment scan controller with bus-writable
//            display register. Optional leading-zero blanking: SEVEN_SEG_LZB_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_ctrl #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [31:0]         data_i,
  input  logic                en_i,
  output logic [31:0]         data_o,
  output logic [N_DIGITS-1:0] an_o,
  output logic [3:0]          digit_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0]    c_cnt_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]    c_idx_last = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] c_an_rst   = ~(N_DIGITS'(1));

  logic [31:0]         r_reg;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic                w_tc;
  logic [3:0]          w_nib;
  logic [N_DIGITS-1:0] w_an;

  assign data_o = r_reg;
  assign w_tc   = en_i && (r_cnt == c_cnt_last);

  always_comb begin
    w_nib = 4'h0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) w_nib = r_reg[4*k +: 4];
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic                w_zero_from;
  logic [N_DIGITS-1:0] w_blank;

  // Digit k is blanked when it and every more significant digit are zero.
  always_comb begin
    w_zero_from = 1'b1;
    w_blank     = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_zero_from = w_zero_from && (r_reg[4*k +: 4] == 4'h0);
      w_blank[k]  = w_zero_from;
    end
  end

  always_comb begin
    w_an = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_an[k] = (r_idx != IDX_W'(k)) || w_blank[k];
    end
  end
`else
  always_comb begin
    w_an = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_an[k] = (r_idx != IDX_W'(k));
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_reg   <= 32'h0;
      r_cnt   <= '0;
      r_idx   <= '0;
      an_o    <= c_an_rst;
      digit_o <= 4'h0;
    end else begin
      if (we_i) r_reg <= data_i;
      if (en_i) begin
        if (w_tc) begin
          r_cnt <= '0;
          r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      // Outputs follow the registered index/register, so they lag a TC or
      // write by one cycle.
      an_o    <= en_i ? w_an : '1;
      digit_o <= w_nib;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Brief    : Scoreboard bench for seven_seg_scan_ctrl (N_DIGITS=8, REFRESH_DIV=4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_ctrl;

  localparam int ND = 8;
  localparam int RD = 4;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] din;
  logic        en;
  logic [31:0] dout;
  logic [7:0]  an;
  logic [3:0]  dig;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0]  an;
    logic [3:0]  dig;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  // reference state
  logic [31:0] m_reg;
  int          m_cnt;
  int          m_idx;

  seven_seg_scan_ctrl #(.N_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (we),
    .data_i (din),
    .en_i   (en),
    .data_o (dout),
    .an_o   (an),
    .digit_o(dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] blank_mask(input logic [31:0] r);
    logic [7:0] b;
    b = 8'h00;
`ifdef SEVEN_SEG_LZB_EN
    for (int k = 1; k < ND; k++) begin
      if ((r >> (4 * k)) == 32'h0) b[k] = 1'b1;
    end
`endif
    return b;
  endfunction

  // Predict the outputs of the coming edge, push them, clock, then compare.
  task automatic step();
    exp_t e;
    exp_t o;
    if (rst) begin
      m_reg = 32'h0; m_cnt = 0; m_idx = 0;
      e.an  = 8'hFE; e.dig = 4'h0;
    end else begin
      e.an  = en ? (~(8'h01 << m_idx) | blank_mask(m_reg)) : 8'hFF;
      e.dig = 4'((m_reg >> (4 * m_idx)) & 32'hF);
      if (we) m_reg = din;
      if (en) begin
        if (m_cnt == RD - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % ND;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    e.data = m_reg;
    q.push_back(e);
    @(posedge clk);
    #1;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: queue empty, required an entry");
    end else begin
      o = q.pop_front();
      if (an !== o.an) begin
        bad++;
        $display("FAIL sb_an: got %h required %h", an, o.an);
      end
      if (dig !== o.dig) begin
        bad++;
        $display("FAIL sb_digit: got %h required %h", dig, o.dig);
      end
      if (dout !== o.data) begin
        bad++;
        $display("FAIL sb_data: got %h required %h", dout, o.data);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; en = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; we = 1'b1; din = 32'hDEADBEEF; en = 1'b1;
    step();
    we = 1'b0; en = 1'b0;
    step();
    total++;
    if (an !== 8'hFE || dig !== 4'h0 || dout !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: an=%h dig=%h data=%h required FE 0 00000000", an, dig, dout);
    end
    rst = 1'b0; en = 1'b1;
    n = 0;
    while (an !== 8'hFD && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL reset_first_tc: an=FD after %0d cycles, required 5", n);
    end
  endtask

  task automatic test_full_scan();
    int k;
    do_reset();
    we = 1'b1; din = 32'h76543210;
    for (int s = 1; s <= 36; s++) begin
      step();
      we = 1'b0;
      k = ((s - 1) / 4) % 8;
      total++;
      if (an !== ~(8'h01 << k) || dig !== 4'(k)) begin
        bad++;
        $display("FAIL full_scan s=%0d: an=%h dig=%h required %h %h", s, an, dig, ~(8'h01 << k), k);
      end
    end
  endtask

  task automatic test_mid_write();
    do_reset();
    for (int s = 1; s <= 17; s++) begin
      we  = (s == 1) || (s == 14);
      din = (s == 1) ? 32'h76543210 : 32'hFFFFFFFF;
      step();
      if (s >= 15) begin
        total++;
        if (dig !== 4'hF || an !== ((s == 17) ? 8'hEF : 8'hF7)) begin
          bad++;
          $display("FAIL mid_write s=%0d: an=%h dig=%h required %h F", s, an, dig,
                   (s == 17) ? 8'hEF : 8'hF7);
        end
      end
    end
    we = 1'b0;
  endtask

  task automatic test_en_hold();
    do_reset();
    for (int s = 1; s <= 35; s++) begin
      we  = (s == 1);
      din = 32'h76543210;
      en  = !(s >= 23 && s <= 32);
      step();
      if (s >= 23 && s <= 32) begin
        total++;
        if (an !== 8'hFF || dig !== 4'h5) begin
          bad++;
          $display("FAIL en_hold s=%0d: an=%h dig=%h required FF 5", s, an, dig);
        end
      end else if (s >= 33) begin
        total++;
        if (an !== ((s == 35) ? 8'hBF : 8'hDF)) begin
          bad++;
          $display("FAIL en_resume s=%0d: an=%h required %h", s, an, (s == 35) ? 8'hBF : 8'hDF);
        end
      end
    end
    we = 1'b0; en = 1'b1;
  endtask

  task automatic test_write_on_tc();
    do_reset();
    for (int s = 1; s <= 5; s++) begin
      we  = (s == 4);
      din = 32'h000000A0;
      step();
    end
    we = 1'b0;
    total++;
    if (an !== 8'hFD || dig !== 4'hA) begin
      bad++;
      $display("FAIL write_on_tc: an=%h dig=%h required FD A", an, dig);
    end
  endtask

  task automatic test_lzb(input logic [31:0] val, input logic [7:0] lit_lzb);
    logic [7:0] lit;
    logic [7:0] req;
    do_reset();
    lit = 8'h00;
    we = 1'b1; din = val;
    for (int s = 1; s <= 40; s++) begin
      step();
      we = 1'b0;
      lit = lit | ~an;
      if (an === 8'hFD) begin
        total++;
        if (dig !== 4'((val >> 4) & 32'hF)) begin
          bad++;
          $display("FAIL lzb_digit1 val=%h: dig=%h required %h", val, dig, (val >> 4) & 32'hF);
        end
      end
    end
`ifdef SEVEN_SEG_LZB_EN
    req = lit_lzb;
`else
    req = 8'hFF;
`endif
    total++;
    if (lit !== req) begin
      bad++;
      $display("FAIL lzb_lit val=%h: lit=%h required %h", val, lit, req);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      we  = 1'b1;
      v   = $urandom;
      din = v;
      en  = ($urandom_range(0, 3) != 0);
      step();
      total++;
      if (dout !== v) begin
        bad++;
        $display("FAIL b2b_data s=%0d: data=%h required %h", s, dout, v);
      end
    end
    // reset together with a write: reset wins
    rst = 1'b1; we = 1'b1; din = 32'h12345678; en = 1'b1;
    step();
    rst = 1'b0; we = 1'b0;
    total++;
    if (dout !== 32'h0 || an !== 8'hFE || dig !== 4'h0) begin
      bad++;
      $display("FAIL reset_over_write: data=%h an=%h dig=%h required 0 FE 0", dout, an, dig);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; din = 32'h0; en = 1'b0;
    m_reg = 32'h0; m_cnt = 0; m_idx = 0;
    test_reset();
    test_full_scan();
    test_mid_write();
    test_en_hold();
    test_write_on_tc();
    test_lzb(32'h00000305, 8'h07);
    test_lzb(32'h00000000, 8'h01);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8, SHALL set the number of multiplexed display digits (legal range 1..8).
REQ-002 Parameter REFRESH_DIV, default 100000, SHALL set the number of clk_i cycles each digit stays selected (legal range 2..2^20).
REQ-003 clk_i  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 we_i  input  1  SHALL be the write strobe from the peripheral bus decoder.
REQ-006 data_i  input  32  SHALL be the write data; nibble k SHALL map to digit k.
REQ-007 en_i  input  1  SHALL be the display enable; 1 SHALL mean scan active.
REQ-008 data_o  output  32  SHALL be the readback of the display register.
REQ-009 an_o  output  N_DIGITS  SHALL be the digit anodes, active low, at most one bit low.
REQ-010 digit_o  output  4  SHALL be the nibble for the selected digit; it drives the 4-to-7 segment decoder.

Function
REQ-011 The display register SHALL load data_i on the first rising edge with we_i=1; data_o SHALL equal the register.
REQ-012 The refresh counter SHALL count 0..REFRESH_DIV-1 while en_i=1, then wrap to 0. This wrap is the terminal count (TC).
REQ-013 On TC the digit index SHALL advance idx -> idx+1, and wrap from N_DIGITS-1 to 0.
REQ-014 an_o and digit_o SHALL be registered and SHALL reflect a new idx one cycle after TC.
REQ-015 In steady state, an_o[idx] SHALL be 0 and all other bits 1. digit_o SHALL be register[4*idx+3:4*idx].
REQ-016 A write during a scan SHALL NOT restart the counter or change idx.
REQ-017 After a write, digit_o SHALL show the new nibble for the current idx one cycle after the write edge.
REQ-018 While en_i=0, the counter and idx SHALL hold, and an_o SHALL be all 1s from the next cycle.
REQ-019 While en_i=0, digit_o SHALL keep tracking the register nibble at idx.
REQ-020 When en_i returns to 1, scanning SHALL resume from the held counter and idx values.
REQ-021 Register nibbles above N_DIGITS-1 SHALL be stored and read back but never displayed.
REQ-022 If we_i and a TC occur in the same cycle, both SHALL take effect. In the following cycle, digit_o SHALL be the new data nibble at the new idx.

Reset
REQ-023 While rst_i=1 at a clock edge, the block SHALL load: display register=0, counter=0, idx=0.
REQ-024 The same reset SHALL load an_o = all 1s except bit 0 = 0, and digit_o=4'h0.
REQ-025 Reset SHALL take priority over we_i and en_i.
REQ-026 Reset asserted mid-scan SHALL take effect at the next edge. No partial write SHALL survive it.
REQ-027 After reset is released, the first TC SHALL occur REFRESH_DIV cycles later.

Configuration
REQ-028 Macro SEVEN_SEG_LZB_EN defined SHALL enable leading-zero blanking.
REQ-029 With blanking, digit k>0 SHALL have its anode held at 1 while register nibbles k..N_DIGITS-1 are all zero.
REQ-030 With blanking, digit 0 SHALL always display, and scan timing and idx sequencing SHALL be unchanged.
REQ-031 Without SEVEN_SEG_LZB_EN, all N_DIGITS digits SHALL display unconditionally and no blanking logic SHALL be synthesized.

Verification
Scenarios use REFRESH_DIV=4 and N_DIGITS=8.
REQ-032 Reset check: assert rst_i for 2 cycles, then release -> an_o=8'hFE, digit_o=0, data_o=0.
REQ-033 Reset check (cont.): after release, an_o becomes 8'hFD exactly 5 cycles later (TC plus one cycle of output latency).
REQ-034 Full scan: write 32'h76543210 -> digit_o runs 0,1,...,7 with matching an_o, each held 4 cycles.
REQ-035 Full scan (cont.): after digit 7 (an_o=8'h7F), the scan wraps to an_o=8'hFE with digit_o=0.
REQ-036 Mid-scan write: while idx=3, write 32'hFFFFFFFF -> digit_o=F on the next cycle, with idx and counter undisturbed.
REQ-037 Enable hold: drop en_i for 10 cycles at idx=5 -> an_o=8'hFF on the following cycle.
REQ-038 Enable hold (cont.): when en_i returns, an_o=8'hDF and the remaining count of the digit-5 period is preserved.
REQ-039 Write on TC: pulse we_i with 32'h000000A0 in the TC cycle of idx 0 -> next cycle an_o=8'hFD and digit_o=A.
REQ-040 With SEVEN_SEG_LZB_EN, write 32'h00000305 -> only digits 0..2 have anodes low. Digit 1 shows 0.
REQ-041 With SEVEN_SEG_LZB_EN, write 32'h0 -> only digit 0 lights, showing 0. Without the macro, all 8 digits light.
